// File: rtl/otp_ctrl_pkg.sv
// rtl/otp_ctrl_pkg.sv - state encoding, default timing and macro timing limits for otp_ctrl
package otp_ctrl_pkg;

    // Access sequence states, in the order the macro sees them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VPP   = 3'd1,
        ST_CSU   = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RECOV = 3'd5
    } otp_state_t;

    // Default phase lengths in CLK cycles, each with margin over the macro limit.
    localparam int DEF_T_VPP   = 20;
    localparam int DEF_T_CS    = 320;
    localparam int DEF_T_PROG  = 15000;
    localparam int DEF_T_READ  = 120;
    localparam int DEF_T_HOLD  = 60;
    localparam int DEF_T_RECOV = 57000;
    localparam int DEF_CNT_W   = 16;

    // Timing limits of the otp_ip macro itself.
    localparam int MACRO_HOLD_MIN  = 50;
    localparam int MACRO_READ_MIN  = 100;
    localparam int MACRO_CS_MIN    = 300;
    localparam int MACRO_PROG_MIN  = 10000;
    localparam int MACRO_PROG_MAX  = 20000;
    localparam int MACRO_RECOV_MIN = 32'hDDDD;

endpackage

// File: rtl/otp_ctrl_timer.sv
// rtl/otp_ctrl_timer.sv - phase counter with clear and compare-to-limit done flag
//  CLK, RST : clock, synchronous active-high reset
//  clr      : restart counting from 0 on the next cycle
//  limit    : terminal count (phase length - 1)
//  done     : counter equals limit this cycle
module otp_ctrl_timer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == limit);

endmodule

// File: rtl/otp_ctrl.sv
// rtl/otp_ctrl.sv - request-to-waveform sequencer for the 128x8 otp_ip macro
//  CLK, RST              : clock, synchronous active-high reset
//  req_valid/req_ready   : single-beat request handshake (ready only in IDLE)
//  req_wr/req_adr/req_din: 1=program, byte address, program data
//  rsp_valid/rsp_rdata   : 1-cycle completion pulse, last read data
//  otp_vpp/cs/prog/read  : macro control strobes
//  otp_adr/otp_din       : macro address and program data
//  otp_do                : macro read data
module otp_ctrl
    import otp_ctrl_pkg::*;
#(
    parameter int T_VPP   = DEF_T_VPP,
    parameter int T_CS    = DEF_T_CS,
    parameter int T_PROG  = DEF_T_PROG,
    parameter int T_READ  = DEF_T_READ,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_RECOV = DEF_T_RECOV,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [6:0] req_adr,
    input  logic [7:0] req_din,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       otp_vpp,
    output logic       otp_cs,
    output logic       otp_prog,
    output logic       otp_read,
    output logic [6:0] otp_adr,
    output logic [7:0] otp_din,
    input  logic [7:0] otp_do
);

    otp_state_t       state, state_next;
    logic             accept;
    logic             done;
    logic             clr;
    logic [CNT_W-1:0] limit;
    logic             wr_q;
    logic             vpp_d, cs_d, prog_d, read_d;

    // req_ready is registered and low in the cycle after reset, so it gates
    // the handshake rather than the IDLE state alone.
    assign accept = req_valid && req_ready;

    always_comb begin
        limit = '0;
        case (state)
            ST_VPP:   limit = CNT_W'(T_VPP - 1);
            ST_CSU:   limit = CNT_W'(T_CS - 1);
            ST_PULSE: limit = wr_q ? CNT_W'(T_PROG - 1) : CNT_W'(T_READ - 1);
            ST_HOLD:  limit = CNT_W'(T_HOLD - 1);
            ST_RECOV: limit = CNT_W'(T_RECOV - 1);
            default:  limit = '0;
        endcase
    end

    // Every state change restarts the phase counter at 0.
    assign clr = (state_next != state);

    otp_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (clr),
        .limit (limit),
        .done  (done)
    );

    // Next state plus the strobe levels that go with it, so the registered
    // strobes line up exactly with the state they belong to.
    always_comb begin
        state_next = state;
        vpp_d      = 1'b0;
        cs_d       = 1'b0;
        prog_d     = 1'b0;
        read_d     = 1'b0;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_VPP;
            ST_VPP:   if (done)   state_next = ST_CSU;
            ST_CSU:   if (done)   state_next = ST_PULSE;
            ST_PULSE: if (done)   state_next = ST_HOLD;
            ST_HOLD:  if (done)   state_next = ST_RECOV;
            ST_RECOV: if (done)   state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
        case (state_next)
            ST_VPP: begin
                vpp_d = 1'b1;
            end
            ST_CSU, ST_HOLD: begin
                vpp_d = 1'b1;
                cs_d  = 1'b1;
            end
            ST_PULSE: begin
                vpp_d  = 1'b1;
                cs_d   = 1'b1;
                prog_d = wr_q;
                read_d = !wr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_q      <= 1'b0;
            otp_vpp   <= 1'b0;
            otp_cs    <= 1'b0;
            otp_prog  <= 1'b0;
            otp_read  <= 1'b0;
            otp_adr   <= '0;
            otp_din   <= '0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == ST_IDLE);
            otp_vpp   <= vpp_d;
            otp_cs    <= cs_d;
            otp_prog  <= prog_d;
            otp_read  <= read_d;
            rsp_valid <= (state == ST_HOLD) && done;
            // Address and data are frozen from the handshake to the end of
            // RECOV so the macro never sees them move while CS is high.
            if (accept) begin
                wr_q    <= req_wr;
                otp_adr <= req_adr;
                otp_din <= req_din;
            end else if (state_next == ST_IDLE) begin
                otp_adr <= '0;
                otp_din <= '0;
            end
            // Sample DO at the end of the READ pulse, when it has settled longest.
            if ((state == ST_PULSE) && done && !wr_q) begin
                rsp_rdata <= otp_do;
            end
        end
    end

endmodule
